// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern source: colour constants,
// pattern mode encodings and raster arithmetic helpers.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_GRAD    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } video_mode_e;

  // 24-bit colours packed as {R,G,B}
  localparam logic [23:0] WHITE   = 24'hFF_FF_FF;
  localparam logic [23:0] YELLOW  = 24'hFF_FF_00;
  localparam logic [23:0] CYAN    = 24'h00_FF_FF;
  localparam logic [23:0] GREEN   = 24'h00_FF_00;
  localparam logic [23:0] MAGENTA = 24'hFF_00_FF;
  localparam logic [23:0] RED     = 24'hFF_00_00;
  localparam logic [23:0] BLUE    = 24'h00_00_FF;
  localparam logic [23:0] BLACK   = 24'h00_00_00;

  // Total pixels (or lines) in one raster period
  function automatic int unsigned video_total(input int unsigned visible,
                                              input int unsigned fp,
                                              input int unsigned pulse,
                                              input int unsigned bp);
    return visible + fp + pulse + bp;
  endfunction

  // Colour of bar number idx, left to right
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing core: hc/vc counters, sync/active decode and the origin,
// line-end and frame-end strobes. Decodes are combinational from the
// counter state; the top level registers them.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONTPORCH = 16,
  parameter int unsigned H_PULSE      = 96,
  parameter int unsigned H_BACKPORCH  = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONTPORCH = 10,
  parameter int unsigned V_PULSE      = 2,
  parameter int unsigned V_BACKPORCH  = 33,
  parameter int unsigned X_WIDTH      = 12,
  parameter int unsigned Y_WIDTH      = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic [X_WIDTH-1:0] hc,
  output logic [Y_WIDTH-1:0] vc,
  output logic               hsync_on,
  output logic               vsync_on,
  output logic               de_on,
  output logic               origin,
  output logic               line_end,
  output logic               frame_end
);

  localparam int unsigned H_TOTAL = video_total(H_VISIBLE, H_FRONTPORCH, H_PULSE, H_BACKPORCH);
  localparam int unsigned V_TOTAL = video_total(V_VISIBLE, V_FRONTPORCH, V_PULSE, V_BACKPORCH);

  localparam logic [X_WIDTH-1:0] H_LAST   = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_LAST   = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] H_VIS    = X_WIDTH'(H_VISIBLE);
  localparam logic [Y_WIDTH-1:0] V_VIS    = Y_WIDTH'(V_VISIBLE);
  localparam logic [X_WIDTH-1:0] HS_START = X_WIDTH'(H_VISIBLE + H_FRONTPORCH);
  localparam logic [X_WIDTH-1:0] HS_END   = X_WIDTH'(H_VISIBLE + H_FRONTPORCH + H_PULSE);
  localparam logic [Y_WIDTH-1:0] VS_START = Y_WIDTH'(V_VISIBLE + V_FRONTPORCH);
  localparam logic [Y_WIDTH-1:0] VS_END   = Y_WIDTH'(V_VISIBLE + V_FRONTPORCH + V_PULSE);

  // Every boundary value, including the totals, must be representable
  if ((H_TOTAL >> X_WIDTH) != 0) begin : g_bad_h_total
    $error("H timing total does not fit in X_WIDTH bits");
  end
  if ((V_TOTAL >> Y_WIDTH) != 0) begin : g_bad_v_total
    $error("V timing total does not fit in Y_WIDTH bits");
  end

  // Pixel/line counters; held at the frame origin while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with <= so every flop samples the pre-edge
    // values; blocking = here would make later reads see the new value.
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!enable) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + Y_WIDTH'(1);
    end else begin
      hc <= hc + X_WIDTH'(1);
    end
  end

  assign hsync_on  = (hc >= HS_START) && (hc < HS_END);
  assign vsync_on  = (vc >= VS_START) && (vc < VS_END);
  assign de_on     = (hc < H_VIS) && (vc < V_VIS);
  assign origin    = enable && (hc == '0) && (vc == '0);
  assign line_end  = enable && (hc == H_LAST);
  assign frame_end = line_end && (vc == V_LAST);

endmodule

// File: rtl/video_pattern_gen.sv
// Programmable-timing test-pattern source for dvi_tx. Wraps the raster
// timing core, generates one of four patterns and registers all outputs
// one cycle after the counter state they describe.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONTPORCH = 16,
  parameter int unsigned H_PULSE      = 96,
  parameter int unsigned H_BACKPORCH  = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONTPORCH = 10,
  parameter int unsigned V_PULSE      = 2,
  parameter int unsigned V_BACKPORCH  = 33,
  parameter bit          H_SYNC       = 1'b0,
  parameter bit          V_SYNC       = 1'b0,
  parameter int unsigned X_WIDTH      = 12,
  parameter int unsigned Y_WIDTH      = 12,
  parameter int unsigned CHECKER_LOG2 = 4,
  parameter int unsigned BOX_SIZE     = 32,
  parameter int unsigned FRAME_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [23:0]            fill_color,
  output logic                   vsync,
  output logic                   hsync,
  output logic                   de,
  output logic [23:0]            data,
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic                   frame_start,
  output logic [FRAME_WIDTH-1:0] frame_count
);

  localparam int unsigned BAR_W = H_VISIBLE / 8;

  localparam logic [X_WIDTH-1:0] BAR_LAST = X_WIDTH'(BAR_W - 1);
  localparam logic [X_WIDTH-1:0] BX_LAST  = X_WIDTH'(H_VISIBLE - BOX_SIZE);
  localparam logic [Y_WIDTH-1:0] BY_LAST  = Y_WIDTH'(V_VISIBLE - BOX_SIZE);
  localparam logic [X_WIDTH-1:0] BOX_X    = X_WIDTH'(BOX_SIZE);
  localparam logic [Y_WIDTH-1:0] BOX_Y    = Y_WIDTH'(BOX_SIZE);

  if ((H_VISIBLE % 8) != 0 || H_VISIBLE < 8) begin : g_bad_h_visible
    $error("H_VISIBLE must be a non-zero multiple of 8");
  end
  if (BOX_SIZE < 1 || BOX_SIZE > H_VISIBLE || BOX_SIZE > V_VISIBLE) begin : g_bad_box
    $error("BOX_SIZE must be between 1 and the visible area");
  end
  if (CHECKER_LOG2 >= X_WIDTH || CHECKER_LOG2 >= Y_WIDTH) begin : g_bad_checker
    $error("CHECKER_LOG2 must index a bit of the pixel counters");
  end

  logic [X_WIDTH-1:0] hc;
  logic [Y_WIDTH-1:0] vc;
  logic               hsync_on;
  logic               vsync_on;
  logic               de_on;
  logic               origin;
  logic               line_end;
  logic               frame_end;

  video_timing_gen #(
    .H_VISIBLE   (H_VISIBLE),
    .H_FRONTPORCH(H_FRONTPORCH),
    .H_PULSE     (H_PULSE),
    .H_BACKPORCH (H_BACKPORCH),
    .V_VISIBLE   (V_VISIBLE),
    .V_FRONTPORCH(V_FRONTPORCH),
    .V_PULSE     (V_PULSE),
    .V_BACKPORCH (V_BACKPORCH),
    .X_WIDTH     (X_WIDTH),
    .Y_WIDTH     (Y_WIDTH)
  ) u_timing (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .hc       (hc),
    .vc       (vc),
    .hsync_on (hsync_on),
    .vsync_on (vsync_on),
    .de_on    (de_on),
    .origin   (origin),
    .line_end (line_end),
    .frame_end(frame_end)
  );

  video_mode_e        mode_r;
  video_mode_e        mode_eff;
  logic [X_WIDTH-1:0] bar_pix;
  logic [2:0]         bar_idx;
  logic [X_WIDTH-1:0] bx;
  logic [Y_WIDTH-1:0] by;
  logic [7:0]         grad;
  logic               in_box;
  logic [23:0]        pixel;

  // Latch the pattern mode once per frame, at the origin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r <= MODE_BARS;
    end else if (origin) begin
      mode_r <= video_mode_e'(mode);
    end
  end

  // Bar position tracked by counting pixels, so no divider is needed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (!enable || line_end) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == BAR_LAST) begin
      bar_pix <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + X_WIDTH'(1);
    end
  end

  // Completed-frame count and moving-box origin, stepped at each frame end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      bx          <= '0;
      by          <= '0;
    end else if (frame_end) begin
      frame_count <= frame_count + FRAME_WIDTH'(1);
      if (frame_count == '1) begin
        bx <= '0;
        by <= '0;
      end else begin
        bx <= (bx == BX_LAST) ? '0 : bx + X_WIDTH'(1);
        by <= (by == BY_LAST) ? '0 : by + Y_WIDTH'(1);
      end
    end
  end

  // Pattern select; the origin pixel already uses the newly sampled mode
  always_comb begin
    // NOTE: pixel gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pixel    = BLACK;
    mode_eff = origin ? video_mode_e'(mode) : mode_r;
    grad     = 8'(hc);
    in_box   = (hc >= bx) && ((hc - bx) < BOX_X) &&
               (vc >= by) && ((vc - by) < BOX_Y);
    case (mode_eff)
      MODE_BARS:    pixel = bar_color(bar_idx);
      MODE_GRAD:    pixel = {grad, grad, grad};
      MODE_CHECKER: pixel = (hc[CHECKER_LOG2] ^ vc[CHECKER_LOG2]) ? BLACK : WHITE;
      MODE_BOX:     pixel = in_box ? WHITE : fill_color;
      default:      pixel = BLACK;
    endcase
  end

  // Output registers: one cycle behind the counters, idle while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync       <= ~V_SYNC;
      hsync       <= ~H_SYNC;
      de          <= 1'b0;
      data        <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      vsync       <= ~V_SYNC;
      hsync       <= ~H_SYNC;
      de          <= 1'b0;
      data        <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      vsync       <= vsync_on ? V_SYNC : ~V_SYNC;
      hsync       <= hsync_on ? H_SYNC : ~H_SYNC;
      de          <= de_on;
      data        <= de_on ? pixel : '0;
      x           <= hc;
      y           <= vc;
      frame_start <= origin;
    end
  end

endmodule
